// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the two-input packet arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package mux_arb_pkg;

  // IDLE arbitrates each cycle; LOCKk holds the grant on input k until its last beat.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_t;

  localparam logic SEL_IN0 = 1'b0;
  localparam logic SEL_IN1 = 1'b1;

endpackage

// File: rtl/stream_reg_slice.sv
// One-entry registered valid/ready slice.
// Latency: one cycle from input handshake to output valid.
// Backpressure: accepts when empty or draining this cycle, so it sustains one beat per cycle.
module stream_reg_slice #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_in_vld,
  output logic         o_in_rdy,
  input  logic [W-1:0] i_in_dat,
  output logic         o_out_vld,
  input  logic         i_out_rdy,
  output logic [W-1:0] o_out_dat
);

  logic         r_vld;
  logic [W-1:0] r_dat;

  assign o_in_rdy  = !r_vld || i_out_rdy;
  assign o_out_vld = r_vld;
  assign o_out_dat = r_dat;

  // Load on an accepted beat (a simultaneous drain is implied), otherwise empty on drain.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld <= 1'b0;
      r_dat <= '0;
    end else if (i_in_vld && o_in_rdy) begin
      r_vld <= 1'b1;
      r_dat <= i_in_dat;
    end else if (i_out_rdy) begin
      r_vld <= 1'b0;
    end
  end

endmodule

// File: rtl/mux_21_stream_arb.sv
// Round-robin two-input packet arbiter that drives mux_21 sel and registers the winning beat.
// Latency: one cycle from input transfer to out_valid; no bubble between packets.
// Backpressure: a full, stalled output slice deasserts both input readies and freezes arbitration.
module mux_21_stream_arb
  import mux_arb_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_0_valid,
  output logic              in_0_ready,
  input  logic [DATA_W-1:0] in_0_data,
  input  logic              in_0_last,
  input  logic              in_1_valid,
  output logic              in_1_ready,
  input  logic [DATA_W-1:0] in_1_data,
  input  logic              in_1_last,
  output logic              sel,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic [CNT_W-1:0]  pkt_cnt
);

  arb_state_t         r_state;
  arb_state_t         w_state_nxt;
  logic               r_prio;
  logic [CNT_W-1:0]   r_pkt_cnt;

  logic               w_grant0;
  logic               w_grant1;
  logic               w_sel;
  logic               w_pipe_ready;
  logic               w_xfer;
  logic               w_beat_last;
  logic [DATA_W-1:0]  w_beat_data;
  logic [DATA_W:0]    w_slice_dat;

  // Grant selection and next state; IDLE grants combinationally so the first beat moves without a bubble.
  always_comb begin
    w_grant0    = 1'b0;
    w_grant1    = 1'b0;
    w_sel       = r_prio;
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (in_0_valid && (!in_1_valid || (r_prio == SEL_IN0))) begin
          w_grant0 = 1'b1;
          w_sel    = SEL_IN0;
        end else if (in_1_valid) begin
          w_grant1 = 1'b1;
          w_sel    = SEL_IN1;
        end
      end
      LOCK0: begin
        w_grant0 = 1'b1;
        w_sel    = SEL_IN0;
      end
      LOCK1: begin
        w_grant1 = 1'b1;
        w_sel    = SEL_IN1;
      end
      default: begin
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
      end
    endcase

    in_0_ready  = !reset && w_pipe_ready && w_grant0;
    in_1_ready  = !reset && w_pipe_ready && w_grant1;
    w_xfer      = (in_0_valid && in_0_ready) || (in_1_valid && in_1_ready);
    w_beat_last = (w_sel == SEL_IN1) ? in_1_last : in_0_last;
    w_beat_data = (w_sel == SEL_IN1) ? in_1_data : in_0_data;

    if (w_xfer) begin
      if (w_beat_last) begin
        w_state_nxt = IDLE;
      end else begin
        w_state_nxt = (w_sel == SEL_IN1) ? LOCK1 : LOCK0;
      end
    end
  end

  // Lock state, round-robin priority and completed-packet count advance only on accepted beats.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_prio    <= SEL_IN0;
      r_pkt_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_xfer && w_beat_last) begin
        r_prio    <= ~w_sel;
        r_pkt_cnt <= r_pkt_cnt + 1'b1;
      end
    end
  end

  stream_reg_slice #(
    .W(DATA_W + 1)
  ) u_out_slice (
    .clk      (clk),
    .reset    (reset),
    .i_in_vld (w_xfer),
    .o_in_rdy (w_pipe_ready),
    .i_in_dat ({w_beat_last, w_beat_data}),
    .o_out_vld(out_valid),
    .i_out_rdy(out_ready),
    .o_out_dat(w_slice_dat)
  );

  assign sel      = w_sel;
  assign out_last = w_slice_dat[DATA_W];
  assign out_data = w_slice_dat[DATA_W-1:0];
  assign pkt_cnt  = r_pkt_cnt;

endmodule

// File: tb/tb_mux_21_stream_arb.sv
// Bench for mux_21_stream_arb: packet-level reference model plus directed scenarios.
// Latency: n/a.
// Backpressure: driven from per-test out_ready patterns.
module tb_mux_21_stream_arb;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_0_valid, in_0_last, in_1_valid, in_1_last, out_ready;
  logic [7:0] in_0_data, in_1_data;
  logic       in_0_ready, in_1_ready, sel, out_valid, out_last;
  logic [7:0] out_data, pkt_cnt;

  logic       c2_in_0_ready, c2_in_1_ready, c2_sel, c2_out_valid, c2_out_last;
  logic [7:0] c2_out_data;
  logic [1:0] c2_pkt_cnt;

  always #5 clk = ~clk;

  mux_21_stream_arb dut (
    .clk(clk), .reset(reset),
    .in_0_valid(in_0_valid), .in_0_ready(in_0_ready), .in_0_data(in_0_data), .in_0_last(in_0_last),
    .in_1_valid(in_1_valid), .in_1_ready(in_1_ready), .in_1_data(in_1_data), .in_1_last(in_1_last),
    .sel(sel), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .pkt_cnt(pkt_cnt)
  );

  mux_21_stream_arb #(.DATA_W(8), .CNT_W(2)) dut_c2 (
    .clk(clk), .reset(reset),
    .in_0_valid(in_0_valid), .in_0_ready(c2_in_0_ready), .in_0_data(in_0_data), .in_0_last(in_0_last),
    .in_1_valid(in_1_valid), .in_1_ready(c2_in_1_ready), .in_1_data(in_1_data), .in_1_last(in_1_last),
    .sel(c2_sel), .out_valid(c2_out_valid), .out_ready(out_ready), .out_data(c2_out_data),
    .out_last(c2_out_last), .pkt_cnt(c2_pkt_cnt)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  logic [8:0] q0[$];
  logic [8:0] q1[$];
  bit         ordy_pat[$];
  logic [7:0] acc_log[$];
  int         acc_cyc[$];
  logic [7:0] out_log[$];
  int         out_cyc[$];
  logic [1:0] cnt2_log[$];

  // Packet-level reference: owner of the open packet (-1 = none), priority, output beat, packet count.
  int         m_owner;
  int         m_prio;
  bit         m_ov;
  logic [7:0] m_od;
  logic       m_ol;
  int         m_cnt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // Per-cycle compare against the reference, logging, then reference update for the coming edge.
  always @(negedge clk) begin
    int         want;
    int         esel;
    bit         pok, e0, e1, take;
    logic [8:0] beat;
    cyc++;
    pok = !m_ov || out_ready;
    if (m_owner >= 0)                want = m_owner;
    else if (in_0_valid && in_1_valid) want = m_prio;
    else if (in_0_valid)             want = 0;
    else if (in_1_valid)             want = 1;
    else                             want = -1;
    esel = (want >= 0) ? want : m_prio;
    e0 = !reset && pok && (want == 0);
    e1 = !reset && pok && (want == 1);
    if (chk_en) begin
      chk("in_0_ready", {31'd0, in_0_ready}, {31'd0, e0});
      chk("in_1_ready", {31'd0, in_1_ready}, {31'd0, e1});
      chk("sel", {31'd0, sel}, esel);
      chk("out_valid", {31'd0, out_valid}, {31'd0, m_ov});
      if (m_ov) begin
        chk("out_data", {24'd0, out_data}, {24'd0, m_od});
        chk("out_last", {31'd0, out_last}, {31'd0, m_ol});
      end
      chk("pkt_cnt", {24'd0, pkt_cnt}, m_cnt % 256);
      chk("pkt_cnt_w2", {30'd0, c2_pkt_cnt}, m_cnt % 4);
    end
    if (in_0_valid && in_0_ready) begin acc_log.push_back(in_0_data); acc_cyc.push_back(cyc); end
    if (in_1_valid && in_1_ready) begin acc_log.push_back(in_1_data); acc_cyc.push_back(cyc); end
    if (out_valid && out_ready) begin out_log.push_back(out_data); out_cyc.push_back(cyc); end
    cnt2_log.push_back(c2_pkt_cnt);
    if (reset) begin
      m_owner = -1; m_prio = 0; m_ov = 0; m_od = 8'h00; m_ol = 0; m_cnt = 0;
    end else begin
      take = (e0 && in_0_valid) || (e1 && in_1_valid);
      if (take) begin
        beat = (want == 1) ? {in_1_last, in_1_data} : {in_0_last, in_0_data};
        m_ov = 1; m_od = beat[7:0]; m_ol = beat[8];
        if (beat[8]) begin
          m_cnt++;
          m_owner = -1;
          m_prio = 1 - want;
        end else begin
          m_owner = want;
        end
      end else if (out_ready) begin
        m_ov = 0;
      end
    end
  end

  task automatic run(input int n);
    bit a0, a1;
    for (int i = 0; i < n; i++) begin
      in_0_valid = (q0.size() > 0);
      in_0_data  = (q0.size() > 0) ? q0[0][7:0] : 8'h00;
      in_0_last  = (q0.size() > 0) ? q0[0][8] : 1'b0;
      in_1_valid = (q1.size() > 0);
      in_1_data  = (q1.size() > 0) ? q1[0][7:0] : 8'h00;
      in_1_last  = (q1.size() > 0) ? q1[0][8] : 1'b0;
      out_ready  = (ordy_pat.size() > 0) ? ordy_pat.pop_front() : 1'b1;
      @(negedge clk);
      a0 = in_0_valid && in_0_ready;
      a1 = in_1_valid && in_1_ready;
      @(posedge clk); #1;
      if (a0) void'(q0.pop_front());
      if (a1) void'(q1.pop_front());
    end
  endtask

  task automatic clear_logs();
    acc_log.delete(); acc_cyc.delete(); out_log.delete(); out_cyc.delete(); cnt2_log.delete();
  endtask

  task automatic do_reset();
    q0.delete(); q1.delete(); ordy_pat.delete();
    reset = 1'b1;
    run(1);
    reset = 1'b0;
    clear_logs();
  endtask

  initial begin
    reset = 1'b1;
    in_0_valid = 0; in_0_data = 0; in_0_last = 0;
    in_1_valid = 0; in_1_data = 0; in_1_last = 0;
    out_ready = 1'b1;
    m_owner = -1; m_prio = 0; m_ov = 0; m_od = 0; m_ol = 0; m_cnt = 0;
    repeat (2) begin @(posedge clk); #1; end
    chk_en = 1'b1;
    chk("reset out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset pkt_cnt", {24'd0, pkt_cnt}, 32'd0);
    chk("reset sel", {31'd0, sel}, 32'd0);
    reset = 1'b0;
    clear_logs();

    // Single 3-beat packet on in_0.
    q0 = '{9'h0A0, 9'h0A1, 9'h1A2};
    run(6);
    chk("t1 out0", {24'd0, out_log[0]}, 32'hA0);
    chk("t1 out1", {24'd0, out_log[1]}, 32'hA1);
    chk("t1 out2", {24'd0, out_log[2]}, 32'hA2);
    chk("t1 latency", out_cyc[0], acc_cyc[0] + 1);
    chk("t1 out spacing", out_cyc[2], out_cyc[0] + 2);
    chk("t1 pkt_cnt", {24'd0, pkt_cnt}, 32'd1);

    // Contention with 2-beat packets: in_0, in_1, in_0.
    do_reset();
    q0 = '{9'h010, 9'h111, 9'h012, 9'h113};
    q1 = '{9'h020, 9'h121};
    run(8);
    chk("t2 n", acc_log.size(), 32'd6);
    chk("t2 a0", {24'd0, acc_log[0]}, 32'h10);
    chk("t2 a1", {24'd0, acc_log[1]}, 32'h11);
    chk("t2 a2", {24'd0, acc_log[2]}, 32'h20);
    chk("t2 a3", {24'd0, acc_log[3]}, 32'h21);
    chk("t2 a4", {24'd0, acc_log[4]}, 32'h12);
    chk("t2 a5", {24'd0, acc_log[5]}, 32'h13);

    // Four-cycle output stall while beat 2 waits.
    do_reset();
    q0 = '{9'h030, 9'h031, 9'h132};
    ordy_pat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    run(4);
    chk("t3 hold data", {24'd0, out_data}, 32'h31);
    chk("t3 hold ready", {31'd0, in_0_ready}, 32'd0);
    run(5);
    chk("t3 n", out_log.size(), 32'd3);
    chk("t3 o0", {24'd0, out_log[0]}, 32'h30);
    chk("t3 o1", {24'd0, out_log[1]}, 32'h31);
    chk("t3 o2", {24'd0, out_log[2]}, 32'h32);

    // Single-beat packets on both inputs: strict alternation, no bubbles.
    do_reset();
    q0 = '{9'h140, 9'h141, 9'h142};
    q1 = '{9'h150, 9'h151, 9'h152};
    run(8);
    chk("t4 a0", {24'd0, acc_log[0]}, 32'h40);
    chk("t4 a1", {24'd0, acc_log[1]}, 32'h50);
    chk("t4 a2", {24'd0, acc_log[2]}, 32'h41);
    chk("t4 a5", {24'd0, acc_log[5]}, 32'h52);
    chk("t4 no bubble", acc_cyc[5], acc_cyc[0] + 5);
    chk("t4 pkt_cnt", {24'd0, pkt_cnt}, 32'd6);

    // Two-bit counter wraps after the fourth packet.
    do_reset();
    q0 = '{9'h160, 9'h161, 9'h162, 9'h163, 9'h164};
    run(7);
    chk("t5 cnt1", {30'd0, cnt2_log[1]}, 32'd1);
    chk("t5 cnt2", {30'd0, cnt2_log[2]}, 32'd2);
    chk("t5 cnt3", {30'd0, cnt2_log[3]}, 32'd3);
    chk("t5 cnt4", {30'd0, cnt2_log[4]}, 32'd0);
    chk("t5 cnt5", {30'd0, cnt2_log[5]}, 32'd1);
    chk("t5 cnt8", {24'd0, pkt_cnt}, 32'd5);

    // Reset inside a locked in_1 packet; priority was left favouring in_1.
    clear_logs();
    q1 = '{9'h070, 9'h071, 9'h172};
    run(1);
    chk("t6 locked valid", {31'd0, out_valid}, 32'd1);
    reset = 1'b1;
    run(1);
    reset = 1'b0;
    q0.delete(); q1.delete();
    chk("t6 out_valid", {31'd0, out_valid}, 32'd0);
    chk("t6 pkt_cnt", {24'd0, pkt_cnt}, 32'd0);
    clear_logs();
    q0 = '{9'h180};
    q1 = '{9'h190};
    run(3);
    chk("t6 first", {24'd0, acc_log[0]}, 32'h80);
    chk("t6 second", {24'd0, acc_log[1]}, 32'h90);

    run(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
